// File: rtl/cpu_alu_stage.sv
// cpu_alu_stage: 8-bit SM83 execute/writeback stage sitting beside the register file.
// Drives the file's read selects, computes the ALU result on the returned operands
// (with write-port bypass), and writes the result back one cycle later. Owns flags F.
// 16-bit ADD rr,rr is split into a low-byte cycle and a high-byte cycle.
module cpu_alu_stage (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [3:0] i_op,
  input  logic [2:0] i_dst_sel,
  input  logic [2:0] i_src_sel,
  output logic [2:0] o_reg_a_sel,
  output logic [2:0] o_reg_b_sel,
  input  logic [7:0] i_reg_a,
  input  logic [7:0] i_reg_b,
  output logic [2:0] o_reg_wr_sel,
  output logic       o_reg_wr_en,
  output logic [7:0] o_reg_wr_data,
  output logic [3:0] o_flags
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADC   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SBC   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_CP    = 4'd7;
  localparam logic [3:0] OP_INC   = 4'd8;
  localparam logic [3:0] OP_DEC   = 4'd9;
  localparam logic [3:0] OP_DAA   = 4'd10;
  localparam logic [3:0] OP_CPL   = 4'd11;
  localparam logic [3:0] OP_ADD16 = 4'd12;

  typedef enum logic {IDLE, ADD16_HI} state_t;

  state_t     state, state_next;
  logic [1:0] pair_d, pair_s, pair_d_next, pair_s_next;
  logic       carry16, carry16_next;
  logic       accept, cin;
  logic [7:0] opa, opb, res;
  logic [8:0] add9, sub9;
  logic [4:0] add5, sub5;
  logic [7:0] daa_adj, daa_res;
  logic       daa_c;
  logic       wr_en_next;
  logic [2:0] wr_sel_next;
  logic [7:0] wr_data_next;
  logic [3:0] flags_next;

  // Flag bit positions inside o_flags = {Z,N,H,C}
  wire f_z = o_flags[3];
  wire f_n = o_flags[2];
  wire f_h = o_flags[1];
  wire f_c = o_flags[0];

  assign o_ready = (state == IDLE);
  assign accept  = i_valid && o_ready;

  // Register-file read selects: low bytes on ADD16 accept, latched high bytes in ADD16_HI
  always_comb begin
    o_reg_a_sel = i_dst_sel;
    o_reg_b_sel = i_src_sel;
    if (state == ADD16_HI) begin
      o_reg_a_sel = {pair_d, 1'b0};
      o_reg_b_sel = {pair_s, 1'b0};
    end else if (i_op == OP_ADD16) begin
      o_reg_a_sel = {i_dst_sel[2:1], 1'b1};
      o_reg_b_sel = {i_src_sel[2:1], 1'b1};
    end
  end

  // The file has not yet committed last cycle's result, so forward it
  assign opa = (o_reg_wr_en && (o_reg_a_sel == o_reg_wr_sel)) ? o_reg_wr_data : i_reg_a;
  assign opb = (o_reg_wr_en && (o_reg_b_sel == o_reg_wr_sel)) ? o_reg_wr_data : i_reg_b;

  // Carry-in: latched low-byte carry for the high step, F.C for ADC/SBC, else zero
  assign cin = (state == ADD16_HI) ? carry16 :
               (((i_op == OP_ADC) || (i_op == OP_SBC)) ? f_c : 1'b0);

  // Bit 8 / bit 4 are the carry (add) or borrow (sub) out of the 8-bit / nibble operation
  assign add9 = {1'b0, opa} + {1'b0, opb} + {8'd0, cin};
  assign add5 = {1'b0, opa[3:0]} + {1'b0, opb[3:0]} + {4'd0, cin};
  assign sub9 = {1'b0, opa} - {1'b0, opb} - {8'd0, cin};
  assign sub5 = {1'b0, opa[3:0]} - {1'b0, opb[3:0]} - {4'd0, cin};

  // Decimal adjust of operand A, decided from the original value and current N/H/C
  always_comb begin
    daa_adj = 8'h00;
    daa_c   = f_c;
    daa_res = opa;
    if (!f_n) begin
      if (f_c || (opa > 8'h99)) begin
        daa_adj = 8'h60;
        daa_c   = 1'b1;
      end
      if (f_h || (opa[3:0] > 4'd9)) daa_adj = daa_adj | 8'h06;
      daa_res = opa + daa_adj;
    end else begin
      if (f_c) daa_adj = 8'h60;
      if (f_h) daa_adj = daa_adj | 8'h06;
      daa_res = opa - daa_adj;
    end
  end

  // Next-state, write-port and flag computation
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_next   = state;
    pair_d_next  = pair_d;
    pair_s_next  = pair_s;
    carry16_next = carry16;
    wr_en_next   = 1'b0;
    wr_sel_next  = o_reg_wr_sel;
    wr_data_next = o_reg_wr_data;
    flags_next   = o_flags;
    res          = 8'h00;

    if (state == ADD16_HI) begin
      wr_en_next   = 1'b1;
      wr_sel_next  = {pair_d, 1'b0};
      wr_data_next = add9[7:0];
      flags_next   = {f_z, 1'b0, add5[4], add9[8]};
      state_next   = IDLE;
    end else if (accept) begin
      wr_sel_next = i_dst_sel;
      case (i_op)
        OP_ADD, OP_ADC: begin
          res        = add9[7:0];
          wr_en_next = 1'b1;
          flags_next = {res == 8'h00, 1'b0, add5[4], add9[8]};
        end
        OP_SUB, OP_SBC, OP_CP: begin
          res        = sub9[7:0];
          wr_en_next = (i_op != OP_CP);
          flags_next = {res == 8'h00, 1'b1, sub5[4], sub9[8]};
        end
        OP_AND: begin
          res        = opa & opb;
          wr_en_next = 1'b1;
          flags_next = {res == 8'h00, 1'b0, 1'b1, 1'b0};
        end
        OP_XOR, OP_OR: begin
          res        = (i_op == OP_XOR) ? (opa ^ opb) : (opa | opb);
          wr_en_next = 1'b1;
          flags_next = {res == 8'h00, 1'b0, 1'b0, 1'b0};
        end
        OP_INC: begin
          res        = opa + 8'd1;
          wr_en_next = 1'b1;
          flags_next = {res == 8'h00, 1'b0, opa[3:0] == 4'hF, f_c};
        end
        OP_DEC: begin
          res        = opa - 8'd1;
          wr_en_next = 1'b1;
          flags_next = {res == 8'h00, 1'b1, opa[3:0] == 4'h0, f_c};
        end
        OP_DAA: begin
          res        = daa_res;
          wr_en_next = 1'b1;
          flags_next = {res == 8'h00, f_n, 1'b0, daa_c};
        end
        OP_CPL: begin
          res        = opa ^ 8'hFF;
          wr_en_next = 1'b1;
          flags_next = {f_z, 1'b1, 1'b1, f_c};
        end
        OP_ADD16: begin
          res          = add9[7:0];
          wr_en_next   = 1'b1;
          wr_sel_next  = {i_dst_sel[2:1], 1'b1};
          carry16_next = add9[8];
          pair_d_next  = i_dst_sel[2:1];
          pair_s_next  = i_src_sel[2:1];
          state_next   = ADD16_HI;
        end
        default: ;
      endcase
      if (wr_en_next) wr_data_next = res;
    end
  end

  // State, write port and flags registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      pair_d        <= 2'd0;
      pair_s        <= 2'd0;
      carry16       <= 1'b0;
      o_reg_wr_en   <= 1'b0;
      o_reg_wr_sel  <= 3'd0;
      o_reg_wr_data <= 8'h00;
      o_flags       <= 4'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples
      // pre-edge values regardless of statement order.
      state         <= state_next;
      pair_d        <= pair_d_next;
      pair_s        <= pair_s_next;
      carry16       <= carry16_next;
      o_reg_wr_en   <= wr_en_next;
      o_reg_wr_sel  <= wr_sel_next;
      o_reg_wr_data <= wr_data_next;
      o_flags       <= flags_next;
    end
  end

endmodule

// File: tb/tb_cpu_alu_stage.sv
// tb_cpu_alu_stage: drives cpu_alu_stage against a small register file, keeps an
// architectural model (registers + flags, whole-word ADD16 arithmetic) and compares
// the write port, flags and ready after every clock. Directed cases pin the model.
module tb_cpu_alu_stage;

  logic       i_clk, i_rst_n, i_valid, o_ready;
  logic [3:0] i_op;
  logic [2:0] i_dst_sel, i_src_sel, o_reg_a_sel, o_reg_b_sel, o_reg_wr_sel;
  logic [7:0] i_reg_a, i_reg_b, o_reg_wr_data;
  logic       o_reg_wr_en;
  logic [3:0] o_flags;

  cpu_alu_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_dst_sel(i_dst_sel), .i_src_sel(i_src_sel),
    .o_reg_a_sel(o_reg_a_sel), .o_reg_b_sel(o_reg_b_sel),
    .i_reg_a(i_reg_a), .i_reg_b(i_reg_b),
    .o_reg_wr_sel(o_reg_wr_sel), .o_reg_wr_en(o_reg_wr_en),
    .o_reg_wr_data(o_reg_wr_data), .o_flags(o_flags)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Register file: commits the write port at the clock edge, loadable by the bench
  logic [7:0] rf [8];
  logic [7:0] ld_vals [8];
  logic       ld_en;
  assign i_reg_a = rf[o_reg_a_sel];
  assign i_reg_b = rf[o_reg_b_sel];
  always @(posedge i_clk) begin
    if (o_reg_wr_en) rf[o_reg_wr_sel] <= o_reg_wr_data;
    else if (ld_en) rf <= ld_vals;
  end

  // Architectural model state and expectations for the next clock
  logic [7:0] m_regs [8];
  logic [3:0] m_flags;
  logic       m_hi_pending, m_hi_h, m_hi_c;
  logic [1:0] m_pd;
  logic [7:0] m_hi_data;
  logic       exp_en, exp_ready;
  logic [2:0] exp_sel;
  logic [7:0] exp_data;
  logic [3:0] exp_flags;
  logic       chk_on;
  int         n_cmp, n_bad;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Compare every cycle, just after the edge, against what the model predicted
  always @(posedge i_clk) begin
    #1;
    if (chk_on && i_rst_n) begin
      check("wr_en", o_reg_wr_en, exp_en);
      if (exp_en) begin
        check("wr_sel", o_reg_wr_sel, exp_sel);
        check("wr_data", o_reg_wr_data, exp_data);
      end
      check("flags", o_flags, exp_flags);
      check("ready", o_ready, exp_ready);
    end
  end

  // One cycle of architectural behaviour for the inputs currently driven
  task automatic model_cycle();
    int a, b, cin, s, r, adj, d16, s16;
    logic z, n, h, c, do_wr;
    logic [2:0] wsel;
    z = m_flags[3]; n = m_flags[2]; h = m_flags[1]; c = m_flags[0];
    do_wr = 1'b0; wsel = i_dst_sel; r = 0; exp_ready = 1'b1;
    if (m_hi_pending) begin
      m_hi_pending = 1'b0;
      do_wr = 1'b1; wsel = {m_pd, 1'b0}; r = int'(m_hi_data);
      n = 1'b0; h = m_hi_h; c = m_hi_c;
    end else if (i_valid) begin
      a = int'(m_regs[i_dst_sel]);
      b = int'(m_regs[i_src_sel]);
      cin = (((i_op == 4'd1) || (i_op == 4'd3)) && c) ? 1 : 0;
      case (i_op)
        4'd0, 4'd1: begin
          s = a + b + cin; r = s & 255; do_wr = 1'b1;
          z = (r == 0); n = 1'b0; h = ((a % 16) + (b % 16) + cin) > 15; c = s > 255;
        end
        4'd2, 4'd3, 4'd7: begin
          s = a - b - cin; r = s & 255; do_wr = (i_op != 4'd7);
          z = (r == 0); n = 1'b1; h = ((a % 16) - (b % 16) - cin) < 0; c = s < 0;
        end
        4'd4: begin r = a & b; do_wr = 1'b1; z = (r == 0); n = 0; h = 1; c = 0; end
        4'd5: begin r = a ^ b; do_wr = 1'b1; z = (r == 0); n = 0; h = 0; c = 0; end
        4'd6: begin r = a | b; do_wr = 1'b1; z = (r == 0); n = 0; h = 0; c = 0; end
        4'd8: begin r = (a + 1) & 255; do_wr = 1'b1; z = (r == 0); n = 0; h = (a % 16) == 15; end
        4'd9: begin r = (a - 1) & 255; do_wr = 1'b1; z = (r == 0); n = 1; h = (a % 16) == 0; end
        4'd10: begin
          adj = 0;
          if (!n) begin
            if (c || a > 'h99) begin adj += 'h60; c = 1'b1; end
            if (h || (a % 16) > 9) adj += 'h06;
            r = (a + adj) & 255;
          end else begin
            if (c) adj += 'h60;
            if (h) adj += 'h06;
            r = (a - adj) & 255;
          end
          do_wr = 1'b1; z = (r == 0); h = 1'b0;
        end
        4'd11: begin r = a ^ 255; do_wr = 1'b1; n = 1; h = 1; end
        4'd12: begin
          d16 = int'(m_regs[{i_dst_sel[2:1], 1'b0}]) * 256 + int'(m_regs[{i_dst_sel[2:1], 1'b1}]);
          s16 = int'(m_regs[{i_src_sel[2:1], 1'b0}]) * 256 + int'(m_regs[{i_src_sel[2:1], 1'b1}]);
          s = d16 + s16;
          do_wr = 1'b1; wsel = {i_dst_sel[2:1], 1'b1}; r = s & 255;
          m_hi_pending = 1'b1; m_pd = i_dst_sel[2:1];
          m_hi_data = 8'((s / 256) & 255);
          m_hi_h = ((d16 % 4096) + (s16 % 4096)) > 4095;
          m_hi_c = s > 65535;
          exp_ready = 1'b0;
        end
        default: ;
      endcase
    end
    m_flags = {z, n, h, c};
    if (do_wr) m_regs[wsel] = r[7:0];
    exp_en = do_wr; exp_sel = wsel; exp_data = r[7:0]; exp_flags = m_flags;
  endtask

  // Drive one cycle of inputs, advance the model, end just after the next edge
  task automatic step(input logic v, input logic [3:0] op, input logic [2:0] d, input logic [2:0] s);
    i_valid = v; i_op = op; i_dst_sel = d; i_src_sel = s;
    model_cycle();
    @(posedge i_clk); #2;
  endtask

  // Load ld_vals into file and model once the write port has gone quiet
  task automatic load_regs();
    step(1'b0, 4'd0, 3'd0, 3'd0);
    step(1'b0, 4'd0, 3'd0, 3'd0);
    ld_en = 1'b1;
    for (int i = 0; i < 8; i++) m_regs[i] = ld_vals[i];
    step(1'b0, 4'd0, 3'd0, 3'd0);
    ld_en = 1'b0;
  endtask

  task automatic random_vals();
    for (int i = 0; i < 8; i++) ld_vals[i] = 8'($urandom_range(0, 255));
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any clock edge
  task automatic mid_reset();
    i_rst_n = 1'b0;
    #1;
    check("rst_flags", o_flags, 4'h0);
    check("rst_wr_en", o_reg_wr_en, 1'b0);
    check("rst_ready", o_ready, 1'b1);
    m_flags = 4'h0; m_hi_pending = 1'b0;
    exp_en = 1'b0; exp_flags = 4'h0; exp_ready = 1'b1;
    i_valid = 1'b0;
    @(posedge i_clk); #2;
    i_rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; chk_on = 1'b0; ld_en = 1'b0;
    i_rst_n = 1'b0; i_valid = 1'b0; i_op = 4'd0; i_dst_sel = 3'd0; i_src_sel = 3'd0;
    m_flags = 4'h0; m_hi_pending = 1'b0; m_pd = 2'd0; m_hi_data = 8'h00;
    m_hi_h = 1'b0; m_hi_c = 1'b0;
    exp_en = 1'b0; exp_sel = 3'd0; exp_data = 8'h00; exp_flags = 4'h0; exp_ready = 1'b1;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    #1;
    check("reset_flags", o_flags, 4'h0);
    check("reset_wr_en", o_reg_wr_en, 1'b0);
    check("reset_ready", o_ready, 1'b1);
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    chk_on = 1'b1;

    // ADD with full carry, then ADC consuming the bypassed result and C
    random_vals(); ld_vals[7] = 8'h3A; ld_vals[0] = 8'hC6; ld_vals[1] = 8'h01;
    load_regs();
    step(1'b1, 4'd0, 3'd7, 3'd0);
    check("add_en", o_reg_wr_en, 1'b1);
    check("add_sel", o_reg_wr_sel, 3'd7);
    check("add_data", o_reg_wr_data, 8'h00);
    check("add_flags", o_flags, 4'b1011);
    step(1'b1, 4'd1, 3'd7, 3'd1);
    check("adc_data", o_reg_wr_data, 8'h02);
    check("adc_flags", o_flags, 4'b0000);

    // CP equal (no write) then SUB with borrow
    random_vals(); ld_vals[7] = 8'h3E; ld_vals[2] = 8'h3E; ld_vals[3] = 8'h40;
    load_regs();
    step(1'b1, 4'd7, 3'd7, 3'd2);
    check("cp_en", o_reg_wr_en, 1'b0);
    check("cp_flags", o_flags, 4'b1100);
    step(1'b1, 4'd2, 3'd7, 3'd3);
    check("sub_data", o_reg_wr_data, 8'hFE);
    check("sub_flags", o_flags, 4'b0101);

    // ADD16 HL += BC; a request during the high step must be ignored
    random_vals(); ld_vals[4] = 8'h8A; ld_vals[5] = 8'h23; ld_vals[0] = 8'h06; ld_vals[1] = 8'h05;
    load_regs();
    step(1'b1, 4'd12, 3'd4, 3'd0);
    check("a16lo_sel", o_reg_wr_sel, 3'd5);
    check("a16lo_data", o_reg_wr_data, 8'h28);
    check("a16lo_flags", o_flags, 4'b0101);
    check("a16lo_ready", o_ready, 1'b0);
    step(1'b1, 4'd0, 3'd7, 3'd1);
    check("a16hi_sel", o_reg_wr_sel, 3'd4);
    check("a16hi_data", o_reg_wr_data, 8'h90);
    check("a16hi_flags", o_flags, 4'b0010);
    check("a16hi_ready", o_ready, 1'b1);
    step(1'b0, 4'd0, 3'd0, 3'd0);
    check("a16_rf_h", rf[4], 8'h90);
    check("a16_rf_l", rf[5], 8'h28);

    // ADD then DAA
    random_vals(); ld_vals[7] = 8'h45; ld_vals[0] = 8'h38;
    load_regs();
    step(1'b1, 4'd0, 3'd7, 3'd0);
    check("bcd_add_data", o_reg_wr_data, 8'h7D);
    step(1'b1, 4'd10, 3'd7, 3'd0);
    check("daa_data", o_reg_wr_data, 8'h83);
    check("daa_flags", o_flags, 4'b0000);

    // Reset while in the ADD16 high step: H must never be written
    random_vals(); ld_vals[4] = 8'h11; ld_vals[5] = 8'h22; ld_vals[0] = 8'h33; ld_vals[1] = 8'h44;
    load_regs();
    step(1'b1, 4'd12, 3'd4, 3'd0);
    check("abort_lo_data", o_reg_wr_data, 8'h66);
    mid_reset();
    step(1'b0, 4'd0, 3'd0, 3'd0);
    step(1'b0, 4'd0, 3'd0, 3'd0);
    check("abort_h_kept", rf[4], 8'h11);
    check("abort_ready", o_ready, 1'b1);

    // Randomized traffic, with a reset dropped into the middle
    for (int i = 0; i < 800; i++) begin
      if (i % 64 == 0) begin
        random_vals();
        load_regs();
      end
      if (i == 400) begin
        mid_reset();
        random_vals();
        load_regs();
      end
      step(($urandom_range(0, 4) != 0), 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    step(1'b0, 4'd0, 3'd0, 3'd0);
    step(1'b0, 4'd0, 3'd0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
